// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  // funct3 encodings for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-enable patterns for lane 0, shifted by addr[1:0]
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational size/alignment logic: byte enables, store-lane replication,
// load lane selection with sign/zero extension, and illegal/misaligned detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        fault
);

  logic [31:0] rdata_sh;

  // Move the addressed lane down to bit 0.
  always_comb begin
    rdata_sh = rdata >> {addr_lo, 3'b000};
  end

  // Decode access size into enables, store data, load extension and fault.
  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    rdata_ext = '0;
    fault     = 1'b0;
    case (funct3)
      F3_B: begin
        be        = BE_BYTE << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      end
      F3_BU: begin
        fault     = is_store;
        be        = BE_BYTE << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h0, rdata_sh[7:0]};
      end
      F3_H: begin
        fault     = addr_lo[0];
        be        = BE_HALF << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      end
      F3_HU: begin
        fault     = is_store | addr_lo[0];
        be        = BE_HALF << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0, rdata_sh[15:0]};
      end
      F3_W: begin
        fault     = (addr_lo != 2'b00);
        be        = BE_WORD;
        rdata_ext = rdata;
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between EX/MEM and a req/gnt/rvalid data-memory port.
// Stalls the upstream pipeline while a bus access is outstanding.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        lsu_stall,
  output logic        lsu_result_valid,
  output logic [31:0] lsu_result,
  output logic        lsu_misaligned,
  output logic        lsu_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e  state_q;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo_q;

  logic        mem_op;
  logic        accept;
  logic        timeout_hit;
  logic [2:0]  align_f3;
  logic [1:0]  align_lo;
  logic        align_store;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;
  logic        align_fault;

  // In IDLE the aligner decodes the incoming request; afterwards it works from
  // the latched access so load extension uses the issuing instruction's size.
  always_comb begin
    if (state_q == StIdle) begin
      align_f3    = req_funct3;
      align_lo    = req_addr[1:0];
      align_store = req_wr;
    end else begin
      align_f3    = f3_q;
      align_lo    = addr_lo_q;
      align_store = dmem_we;
    end
  end

  lsu_align u_align (
    .funct3    (align_f3),
    .is_store  (align_store),
    .addr_lo   (align_lo),
    .wdata     (req_wdata),
    .rdata     (dmem_rdata),
    .be        (align_be),
    .wdata_rep (align_wdata),
    .rdata_ext (align_rdata),
    .fault     (align_fault)
  );

  // Accept decision and stall; stall must rise in the accepting cycle itself.
  always_comb begin
    mem_op    = req_valid & (req_rd | req_wr);
    accept    = (state_q == StIdle) & mem_op & ~align_fault & ~rst;
    lsu_stall = accept | (state_q == StReq) | (state_q == StWait);
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            busy;

  assign busy        = (state_q == StReq) | (state_q == StWait);
  assign timeout_hit = busy & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts every cycle spent in REQ or WAIT, clears elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + CntW'(1);
    end else begin
      cnt_q <= '0;
    end
  end
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
`endif

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      f3_q             <= '0;
      addr_lo_q        <= '0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_be          <= '0;
      dmem_wdata       <= '0;
      lsu_result       <= '0;
      lsu_result_valid <= 1'b0;
      lsu_misaligned   <= 1'b0;
      lsu_bus_err      <= 1'b0;
    end else begin
      lsu_result_valid <= 1'b0;
      lsu_misaligned   <= 1'b0;
      lsu_bus_err      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mem_op && align_fault) begin
            lsu_misaligned <= 1'b1;
          end else if (accept) begin
            state_q    <= StReq;
            f3_q       <= req_funct3;
            addr_lo_q  <= req_addr[1:0];
            dmem_req   <= 1'b1;
            dmem_we    <= req_wr;
            dmem_addr  <= {req_addr[31:2], 2'b00};
            dmem_be    <= align_be;
            dmem_wdata <= req_wr ? align_wdata : '0;
          end
        end
        StReq: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              state_q          <= StDone;
              lsu_result       <= '0;
              lsu_result_valid <= 1'b1;
            end else begin
              state_q <= StWait;
            end
          end else if (timeout_hit) begin
            dmem_req         <= 1'b0;
            state_q          <= StDone;
            lsu_result       <= '0;
            lsu_result_valid <= 1'b1;
            lsu_bus_err      <= 1'b1;
          end
        end
        StWait: begin
          if (dmem_rvalid) begin
            state_q          <= StDone;
            lsu_result       <= align_rdata;
            lsu_result_valid <= 1'b1;
          end else if (timeout_hit) begin
            state_q          <= StDone;
            lsu_result       <= '0;
            lsu_result_valid <= 1'b1;
            lsu_bus_err      <= 1'b1;
          end
        end
        // Pipeline advances on this edge; the instruction still shown is not re-issued.
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
